// File: rtl/icap_arb_pkg.sv
// icap_arbiter shared types: FSM state encoding,
// owner codes and ICAP idle-bus constants.
package icap_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEM_OWN  = 3'd1,
        REL_WAIT = 3'd2,
        GUARD    = 3'd3,
        PRC_OWN  = 3'd4
    } arb_state_e;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_SEM  = 2'd1;
    localparam logic [1:0] OWN_PRC  = 2'd2;

    localparam logic        CSIB_IDLE  = 1'b1;
    localparam logic        RDWRB_IDLE = 1'b1;
    localparam logic [31:0] I_IDLE     = 32'h0;

    function automatic logic [1:0] owner_of(arb_state_e s);
        logic [1:0] o;
        o = OWN_NONE;
        unique case (1'b1)
            (s == SEM_OWN),
            (s == REL_WAIT): o = OWN_SEM;
            (s == PRC_OWN):  o = OWN_PRC;
            default:         o = OWN_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/icap_arbiter_if.sv
// Client/ICAP bundle of the arbiter; slave = arbiter side.
// Stats ports exist only with ICAP_ARB_STATS_EN defined.
interface icap_arbiter_if;
    logic        icap_avail;
    logic        sem_cap_req;
    logic        sem_cap_gnt;
    logic        sem_cap_rel;
    logic        sem_icap_csib;
    logic        sem_icap_rdwrb;
    logic [31:0] sem_icap_i;
    logic        prc_icap_req;
    logic        prc_icap_gnt;
    logic        prc_icap_csib;
    logic        prc_icap_rdwrb;
    logic [31:0] prc_icap_i;
    logic        icap_csib;
    logic        icap_rdwrb;
    logic [31:0] icap_i;
    logic [1:0]  owner;
    logic        rel_timeout;
`ifdef ICAP_ARB_STATS_EN
    logic [15:0] handover_cnt;
    logic [15:0] rel_wait_max;
`endif

    modport slave (
`ifdef ICAP_ARB_STATS_EN
        output handover_cnt,
        output rel_wait_max,
`endif
        input  icap_avail,
        input  sem_cap_req,
        output sem_cap_gnt,
        output sem_cap_rel,
        input  sem_icap_csib,
        input  sem_icap_rdwrb,
        input  sem_icap_i,
        input  prc_icap_req,
        output prc_icap_gnt,
        input  prc_icap_csib,
        input  prc_icap_rdwrb,
        input  prc_icap_i,
        output icap_csib,
        output icap_rdwrb,
        output icap_i,
        output owner,
        output rel_timeout
    );

    modport master (
`ifdef ICAP_ARB_STATS_EN
        input  handover_cnt,
        input  rel_wait_max,
`endif
        output icap_avail,
        output sem_cap_req,
        input  sem_cap_gnt,
        input  sem_cap_rel,
        output sem_icap_csib,
        output sem_icap_rdwrb,
        output sem_icap_i,
        output prc_icap_req,
        input  prc_icap_gnt,
        output prc_icap_csib,
        output prc_icap_rdwrb,
        output prc_icap_i,
        input  icap_csib,
        input  icap_rdwrb,
        input  icap_i,
        input  owner,
        input  rel_timeout
    );
endinterface

// File: rtl/icap_arb_mux.sv
// Registered 3-way ICAP write/control mux. A non-owner
// (or no owner during guard/idle) yields the idle bus.
module icap_arb_mux
    import icap_arb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  sel_i,
    input  logic        sem_csib_i,
    input  logic        sem_rdwrb_i,
    input  logic [31:0] sem_data_i,
    input  logic        prc_csib_i,
    input  logic        prc_rdwrb_i,
    input  logic [31:0] prc_data_i,
    output logic        icap_csib_o,
    output logic        icap_rdwrb_o,
    output logic [31:0] icap_data_o
);
    logic        csib_d, rdwrb_d;
    logic [31:0] data_d;
    logic        csib_q, rdwrb_q;
    logic [31:0] data_q;

    // select the owning client's bus, idle otherwise
    always_comb begin
        csib_d  = CSIB_IDLE;
        rdwrb_d = RDWRB_IDLE;
        data_d  = I_IDLE;
        unique case (1'b1)
            (sel_i == OWN_SEM): begin
                csib_d  = sem_csib_i;
                rdwrb_d = sem_rdwrb_i;
                data_d  = sem_data_i;
            end
            (sel_i == OWN_PRC): begin
                csib_d  = prc_csib_i;
                rdwrb_d = prc_rdwrb_i;
                data_d  = prc_data_i;
            end
            default: ;
        endcase
    end

    // one cycle of latency into the ICAPE3
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            csib_q  <= CSIB_IDLE;
            rdwrb_q <= RDWRB_IDLE;
            data_q  <= I_IDLE;
        end else begin
            csib_q  <= csib_d;
            rdwrb_q <= rdwrb_d;
            data_q  <= data_d;
        end
    end

    assign icap_csib_o  = csib_q;
    assign icap_rdwrb_o = rdwrb_q;
    assign icap_data_o  = data_q;
endmodule

// File: rtl/icap_arbiter.sv
// ICAP owner arbiter between SEM and PRC, PRC priority,
// guard gap on handover. Optional stats: ICAP_ARB_STATS_EN.
module icap_arbiter
    import icap_arb_pkg::*;
#(
    parameter int REL_TIMEOUT  = 4096,
    parameter int GUARD_CYCLES = 4
) (
    input logic           icap_clk,
    input logic           reset,
    icap_arbiter_if.slave bus
);
    localparam logic [15:0] RT = 16'(REL_TIMEOUT);
    localparam logic [15:0] GL = 16'(GUARD_CYCLES - 1);
    localparam arb_state_e  REL_TGT =
        (GUARD_CYCLES == 0) ? IDLE : GUARD;

    arb_state_e  state_q, state_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [15:0] gcnt_q, gcnt_d;
    logic        tout_q, tout_d;
    logic        sgnt_q, sgnt_d;
    logic        pgnt_q, pgnt_d;
    logic        rel_q, rel_d;
    logic [1:0]  own_q, own_d;

    // next state, release-timeout and guard counters
    always_comb begin
        state_d = state_q;
        tcnt_d  = '0;
        gcnt_d  = '0;
        tout_d  = tout_q;
        unique case (state_q)
            IDLE: begin
                if (bus.icap_avail) begin
                    if (bus.prc_icap_req)
                        state_d = PRC_OWN;
                    else if (bus.sem_cap_req)
                        state_d = SEM_OWN;
                end
            end
            SEM_OWN: begin
                if (!bus.sem_cap_req)
                    state_d = REL_TGT;
                else if (bus.prc_icap_req)
                    state_d = REL_WAIT;
            end
            REL_WAIT: begin
                tcnt_d = (tcnt_q >= RT) ? tcnt_q
                                        : tcnt_q + 16'd1;
                if (tcnt_d >= RT)
                    tout_d = 1'b1;
                if (!bus.sem_cap_req)
                    state_d = REL_TGT;
                else if (!bus.prc_icap_req)
                    state_d = SEM_OWN;
            end
            GUARD: begin
                if (gcnt_q >= GL)
                    state_d = IDLE;
                else
                    gcnt_d = gcnt_q + 16'd1;
            end
            PRC_OWN: begin
                if (!bus.prc_icap_req)
                    state_d = REL_TGT;
            end
            default: state_d = IDLE;
        endcase
        sgnt_d = (state_d == SEM_OWN) ||
                 (state_d == REL_WAIT);
        pgnt_d = (state_d == PRC_OWN);
        rel_d  = (state_d == REL_WAIT);
        own_d  = owner_of(state_d);
    end

    // state and registered handshake outputs
    always_ff @(posedge icap_clk) begin
        if (reset) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            tout_q  <= 1'b0;
            sgnt_q  <= 1'b0;
            pgnt_q  <= 1'b0;
            rel_q   <= 1'b0;
            own_q   <= OWN_NONE;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            tout_q  <= tout_d;
            sgnt_q  <= sgnt_d;
            pgnt_q  <= pgnt_d;
            rel_q   <= rel_d;
            own_q   <= own_d;
        end
    end

    assign bus.sem_cap_gnt  = sgnt_q;
    assign bus.prc_icap_gnt = pgnt_q;
    assign bus.sem_cap_rel  = rel_q;
    assign bus.owner        = own_q;
    assign bus.rel_timeout  = tout_q;

    icap_arb_mux u_mux (
        .clk_i        (icap_clk),
        .rst_i        (reset),
        .sel_i        (own_q),
        .sem_csib_i   (bus.sem_icap_csib),
        .sem_rdwrb_i  (bus.sem_icap_rdwrb),
        .sem_data_i   (bus.sem_icap_i),
        .prc_csib_i   (bus.prc_icap_csib),
        .prc_rdwrb_i  (bus.prc_icap_rdwrb),
        .prc_data_i   (bus.prc_icap_i),
        .icap_csib_o  (bus.icap_csib),
        .icap_rdwrb_o (bus.icap_rdwrb),
        .icap_data_o  (bus.icap_i)
    );

`ifdef ICAP_ARB_STATS_EN
    logic        hand, wexit;
    logic [15:0] hcnt_q, hcnt_d;
    logic [15:0] wdur_q, wdur_d, winc;
    logic [15:0] wmax_q, wmax_d;

    assign hand  = (state_q != GUARD) && (state_d == REL_TGT) &&
                   (state_q != IDLE);
    assign wexit = (state_q == REL_WAIT) &&
                   (state_d != REL_WAIT);
    assign winc  = (wdur_q == 16'hFFFF) ? wdur_q
                                        : wdur_q + 16'd1;

    // handover count and longest release wait
    always_comb begin
        hcnt_d = hand ? hcnt_q + 16'd1 : hcnt_q;
        wdur_d = (state_q == REL_WAIT) ? winc : 16'd0;
        wmax_d = (wexit && winc > wmax_q) ? winc : wmax_q;
    end

    // stats registers
    always_ff @(posedge icap_clk) begin
        if (reset) begin
            hcnt_q <= '0;
            wdur_q <= '0;
            wmax_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            wdur_q <= wdur_d;
            wmax_q <= wmax_d;
        end
    end

    assign bus.handover_cnt = hcnt_q;
    assign bus.rel_wait_max = wmax_q;
`endif
endmodule

// File: tb/tb_icap_arbiter.sv
// Directed bench for icap_arbiter (REL_TIMEOUT=16,
// GUARD_CYCLES=4); define ICAP_ARB_STATS_EN for stats checks.
module tb_icap_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  icap_arbiter_if bus ();

  icap_arbiter #(
    .REL_TIMEOUT  (16),
    .GUARD_CYCLES (4)
  ) dut (
    .icap_clk (clk),
    .reset    (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s got=%0h want=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst                = 1'b1;
    bus.icap_avail     = 1'b1;
    bus.sem_cap_req    = 1'b0;
    bus.sem_icap_csib  = 1'b1;
    bus.sem_icap_rdwrb = 1'b1;
    bus.sem_icap_i     = 32'h0;
    bus.prc_icap_req   = 1'b0;
    bus.prc_icap_csib  = 1'b1;
    bus.prc_icap_rdwrb = 1'b1;
    bus.prc_icap_i     = 32'h0;
    tick(2);
    chk("rst_sgnt", bus.sem_cap_gnt, 1'b0);
    chk("rst_pgnt", bus.prc_icap_gnt, 1'b0);
    chk("rst_rel", bus.sem_cap_rel, 1'b0);
    chk("rst_csib", bus.icap_csib, 1'b1);
    chk("rst_rdwrb", bus.icap_rdwrb, 1'b1);
    chk("rst_i", bus.icap_i, 32'h0);
    chk("rst_owner", bus.owner, 2'd0);
    chk("rst_tout", bus.rel_timeout, 1'b0);
    rst = 1'b0;
    tick();

    bus.sem_cap_req    = 1'b1;
    bus.sem_icap_csib  = 1'b0;
    bus.sem_icap_rdwrb = 1'b0;
    bus.sem_icap_i     = 32'hAA995566;
    tick();
    chk("s1_gnt", bus.sem_cap_gnt, 1'b1);
    chk("s1_owner", bus.owner, 2'd1);
    chk("s1_csib_lat", bus.icap_csib, 1'b1);
    tick();
    chk("s1_data", bus.icap_i, 32'hAA995566);
    chk("s1_csib", bus.icap_csib, 1'b0);
    chk("s1_rdwrb", bus.icap_rdwrb, 1'b0);
    bus.sem_cap_req   = 1'b0;
    bus.sem_icap_csib = 1'b1;
    bus.sem_icap_i    = 32'h0;
    tick();
    chk("s1_drop_gnt", bus.sem_cap_gnt, 1'b0);
    chk("s1_drop_own", bus.owner, 2'd0);
    bus.sem_cap_req = 1'b1;
    tick(3);
    chk("s1_guard_gnt", bus.sem_cap_gnt, 1'b0);
    chk("s1_guard_csib", bus.icap_csib, 1'b1);
    chk("s1_guard_i", bus.icap_i, 32'h0);
    tick();
    chk("s1_idle_gnt", bus.sem_cap_gnt, 1'b0);
    tick();
    chk("s1_regnt", bus.sem_cap_gnt, 1'b1);

    bus.sem_icap_csib = 1'b0;
    bus.sem_icap_i    = 32'h11111111;
    tick();
    bus.prc_icap_req   = 1'b1;
    bus.prc_icap_csib  = 1'b0;
    bus.prc_icap_rdwrb = 1'b0;
    bus.prc_icap_i     = 32'h22222222;
    tick();
    chk("p_rel", bus.sem_cap_rel, 1'b1);
    chk("p_sgnt", bus.sem_cap_gnt, 1'b1);
    chk("p_pgnt", bus.prc_icap_gnt, 1'b0);
    chk("p_owner", bus.owner, 2'd1);
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("p_excl",
          bus.sem_cap_gnt & bus.prc_icap_gnt, 1'b0);
      if (i == 15)
        chk("p_tout15", bus.rel_timeout, 1'b0);
      if (i == 16)
        chk("p_tout16", bus.rel_timeout, 1'b1);
      if (i == 20)
        chk("p_semdrv", bus.icap_i, 32'h11111111);
    end
    bus.sem_cap_req   = 1'b0;
    bus.sem_icap_csib = 1'b1;
    bus.sem_icap_i    = 32'h0;
    tick();
    chk("p_relgone", bus.sem_cap_rel, 1'b0);
    chk("p_sgntgone", bus.sem_cap_gnt, 1'b0);
    chk("p_tout_stk", bus.rel_timeout, 1'b1);
    tick(4);
    chk("p_guard_pg", bus.prc_icap_gnt, 1'b0);
    chk("p_guard_cs", bus.icap_csib, 1'b1);
    tick();
    chk("p_pgnt_on", bus.prc_icap_gnt, 1'b1);
    chk("p_owner2", bus.owner, 2'd2);
    tick();
    chk("p_data", bus.icap_i, 32'h22222222);
    chk("p_csib", bus.icap_csib, 1'b0);

    bus.prc_icap_req  = 1'b0;
    bus.prc_icap_csib = 1'b1;
    bus.prc_icap_i    = 32'h0;
    tick(5);
    chk("b_idle_own", bus.owner, 2'd0);
    bus.sem_cap_req  = 1'b1;
    bus.prc_icap_req = 1'b1;
    tick();
    chk("b_pgnt", bus.prc_icap_gnt, 1'b1);
    chk("b_sgnt", bus.sem_cap_gnt, 1'b0);
    tick(3);
    chk("b_sem_wait", bus.sem_cap_gnt, 1'b0);
    chk("b_no_rel", bus.sem_cap_rel, 1'b0);
    bus.prc_icap_req = 1'b0;
    tick(5);
    chk("b_guard_sg", bus.sem_cap_gnt, 1'b0);
    tick();
    chk("b_sgnt_on", bus.sem_cap_gnt, 1'b1);
    chk("b_owner1", bus.owner, 2'd1);

    bus.sem_icap_csib = 1'b0;
    bus.sem_icap_i    = 32'h33333333;
    tick();
    bus.prc_icap_req = 1'b1;
    tick();
    chk("w_rel", bus.sem_cap_rel, 1'b1);
    bus.prc_icap_req = 1'b0;
    tick();
    chk("w_rel_off", bus.sem_cap_rel, 1'b0);
    chk("w_sgnt", bus.sem_cap_gnt, 1'b1);
    chk("w_owner", bus.owner, 2'd1);
    chk("w_data", bus.icap_i, 32'h33333333);
    chk("w_csib", bus.icap_csib, 1'b0);
    tick();
    chk("w_data2", bus.icap_i, 32'h33333333);

    bus.sem_cap_req   = 1'b0;
    bus.sem_icap_csib = 1'b1;
    bus.sem_icap_i    = 32'h0;
    tick(5);
    bus.icap_avail   = 1'b0;
    bus.prc_icap_req = 1'b1;
    tick(2);
    chk("a_nogrant", bus.prc_icap_gnt, 1'b0);
    bus.icap_avail = 1'b1;
    tick();
    chk("a_grant", bus.prc_icap_gnt, 1'b1);
    bus.icap_avail = 1'b0;
    tick(2);
    chk("a_hold", bus.prc_icap_gnt, 1'b1);

    bus.prc_icap_csib = 1'b0;
    bus.prc_icap_i    = 32'hDEADBEEF;
    tick();
    chk("r_pre_i", bus.icap_i, 32'hDEADBEEF);
    chk("r_pre_cs", bus.icap_csib, 1'b0);
`ifdef ICAP_ARB_STATS_EN
    chk("st_hand", bus.handover_cnt, 16'd5);
    chk("st_wmax", bus.rel_wait_max, 16'd41);
`endif
    rst = 1'b1;
    tick();
    chk("r_pgnt", bus.prc_icap_gnt, 1'b0);
    chk("r_sgnt", bus.sem_cap_gnt, 1'b0);
    chk("r_csib", bus.icap_csib, 1'b1);
    chk("r_i", bus.icap_i, 32'h0);
    chk("r_owner", bus.owner, 2'd0);
    chk("r_tout", bus.rel_timeout, 1'b0);
`ifdef ICAP_ARB_STATS_EN
    chk("r_hand", bus.handover_cnt, 16'd0);
    chk("r_wmax", bus.rel_wait_max, 16'd0);
`endif
    rst = 1'b0;
    tick(2);
    chk("r_post_pg", bus.prc_icap_gnt, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/icap_arbiter.md
Name: icap_arbiter

Overview:
- Sits between the SEM controller wrapper, the partial-reconfiguration controller (PRC) and the single ICAPE3 primitive.
- Owns the SEM cap_req/cap_gnt/cap_rel handshake. Multiplexes the ICAP write/control path to exactly one owner.
- PRC has priority: a PRC request forces a SEM release through cap_rel before the PRC is granted.
- Inserts idle guard cycles between owners so the ICAP never sees interleaved transactions.

Parameters:
- REL_TIMEOUT, 4096: cycles to wait for the SEM to drop cap_req after cap_rel before flagging rel_timeout.
- GUARD_CYCLES, 4: idle cycles with csib=1 between ownership changes. 0 means no guard.

Ports:
- icap_clk  in  1  ICAP clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- icap_avail  in  1  ICAP ready for use, from ICAPE3 AVAIL.
- sem_cap_req  in  1  SEM requests ICAP.
- sem_cap_gnt  out  1  SEM granted.
- sem_cap_rel  out  1  arbiter asks SEM to release.
- sem_icap_csib, sem_icap_rdwrb  in  1 each  SEM ICAP control.
- sem_icap_i  in  32  SEM ICAP write data.
- prc_icap_req  in  1  PRC requests ICAP.
- prc_icap_gnt  out  1  PRC granted.
- prc_icap_csib, prc_icap_rdwrb  in  1 each  PRC ICAP control.
- prc_icap_i  in  32  PRC ICAP write data.
- icap_csib, icap_rdwrb  out  1 each  to ICAPE3.
- icap_i  out  32  to ICAPE3.
- owner  out  2  current owner: 0 none, 1 SEM, 2 PRC.
- rel_timeout  out  1  sticky flag: SEM failed to release within REL_TIMEOUT.

Behaviour:
- All outputs are registered.
- Reset values: sem_cap_gnt=0, prc_icap_gnt=0, sem_cap_rel=0, icap_csib=1, icap_rdwrb=1, icap_i=0, owner=0, rel_timeout=0, state=IDLE, counters=0.
- Reset asserted mid-operation aborts everything. Grants drop on the next edge and the ICAP sees csib=1 from the cycle after reset.
- ICAP mux: each cycle, icap_csib/icap_rdwrb/icap_i <= owner's inputs, so there is one cycle of latency.
  - With no owner, or in GUARD, the mux drives csib=1, rdwrb=1, i=0.
  - A non-owner's csib is ignored.
  - ICAP read data (icap_o) goes directly to both clients and is outside this block.
- States: IDLE, SEM_OWN, REL_WAIT, GUARD, PRC_OWN.
- IDLE:
  - Grants only while icap_avail=1.
  - prc_icap_req=1 -> PRC_OWN, prc_icap_gnt=1 on the next edge.
  - Otherwise sem_cap_req=1 -> SEM_OWN, sem_cap_gnt=1.
  - Both requesting in the same cycle -> PRC wins.
- SEM_OWN:
  - sem_cap_req=0 -> GUARD, gnt drops.
  - prc_icap_req=1 -> REL_WAIT, sem_cap_rel=1, timeout counter cleared.
- REL_WAIT:
  - sem_cap_gnt stays 1 and the SEM keeps driving the ICAP.
  - sem_cap_req=0 -> GUARD; sem_cap_rel and sem_cap_gnt drop.
  - prc_icap_req drops before the SEM releases -> back to SEM_OWN, sem_cap_rel=0, no guard.
  - If sem_cap_req=0 and prc_icap_req=0 in the same cycle, the release wins -> GUARD.
  - Timeout counter increments each cycle. On reaching REL_TIMEOUT, rel_timeout=1; it is sticky until reset and the counter saturates.
  - The arbiter never forces a grant away; it stays in REL_WAIT.
- GUARD:
  - Runs GUARD_CYCLES cycles with no grants, then -> IDLE.
  - With GUARD_CYCLES=0, the release edge goes directly to IDLE.
- PRC_OWN:
  - prc_icap_req=0 -> GUARD.
  - A SEM request waits; the SEM is never pre-empted back.
- icap_avail=0 while a client is granted: the grant is held and the clients handle the stall.
- sem_cap_gnt and prc_icap_gnt are never both 1. owner always matches the grant state.

Optional Feature:
- Macro: ICAP_ARB_STATS_EN.
- Defined: adds output ports handover_cnt[15:0] (increments on each entry to GUARD, wraps at 16'hFFFF->0) and rel_wait_max[15:0] (largest REL_WAIT duration in cycles, saturating). Both reset to 0.
- Undefined: neither port nor the counters exist. All other behaviour is identical.

Decomposition:
- Package icap_arb_pkg holds:
  - state encoding enum: IDLE=0, SEM_OWN=1, REL_WAIT=2, GUARD=3, PRC_OWN=4;
  - owner constants OWN_NONE=0, OWN_SEM=1, OWN_PRC=2;
  - ICAP idle constants CSIB_IDLE=1, RDWRB_IDLE=1, I_IDLE=32'h0.
- One natural sub-module: icap_arb_mux, the registered 3-way ICAP mux selected by owner/guard.

Test Plan:
- SEM-only access: sem_cap_req=1 with icap_avail=1. Expect sem_cap_gnt=1 one cycle later and owner=1; sem_icap_i=32'hAA995566 appears on icap_i one cycle after being driven. Drop req -> 4 cycles of csib=1, then IDLE.
- Pre-emption: SEM owns; assert prc_icap_req. Expect sem_cap_rel=1 next cycle. SEM drops req 100 cycles later -> rel and gnt drop, 4 guard cycles, then prc_icap_gnt=1 and owner=2. No cycle has both grants high.
- Simultaneous request from IDLE: both requests high in one cycle -> prc_icap_gnt=1, sem_cap_gnt=0; the SEM is granted only after PRC release plus guard.
- PRC withdrawal: in REL_WAIT, drop prc_icap_req before the SEM releases -> return to SEM_OWN, sem_cap_rel=0, no guard cycles, no glitch on icap_i.
- Timeout: REL_TIMEOUT=16; the SEM holds req 40 cycles after rel -> rel_timeout rises exactly 16 cycles after entering REL_WAIT, stays 1 after handover, clears only on reset.
- Reset mid-PRC write: assert reset while prc_icap_csib=0 -> next cycle both grants are 0, icap_csib=1, icap_i=0, owner=0. With ICAP_ARB_STATS_EN defined, handover_cnt=0.
